// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
// Holds reset/trap PC defaults, PC FSM states and next-PC source codes.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0080;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC priority mux (jr > jump > branch > sequential).
// Ports: pc_plus4, control/target inputs -> next_pc, is_redirect
// (+ misalign when NEXT_PC_MISALIGN_TRAP_EN is defined).
module next_pc_select
    import cpu_pkg::*;
`ifdef NEXT_PC_MISALIGN_TRAP_EN
#(
    parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
)
`endif
(
    input  logic [31:0] pc_plus4,
    input  logic        jump,
    input  logic [27:0] jump_target,
    input  logic        branch,
    input  logic [31:0] branch_offset,
    input  logic        jr,
    input  logic [31:0] jr_target,
`ifdef NEXT_PC_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic [31:0] next_pc,
    output logic        is_redirect
);

    pc_sel_t sel;

    always_comb begin
        sel = SEL_SEQ;
        if (jr)
            sel = SEL_JR;
        else if (jump)
            sel = SEL_J;
        else if (branch)
            sel = SEL_BR;
    end

    always_comb begin
        next_pc     = pc_plus4;
        is_redirect = 1'b1;
`ifdef NEXT_PC_MISALIGN_TRAP_EN
        misalign    = 1'b0;
`endif
        unique case (sel)
            SEL_JR: begin
                next_pc = jr_target;
`ifdef NEXT_PC_MISALIGN_TRAP_EN
                if (jr_target[1:0] != 2'b00) begin
                    next_pc  = TRAP_VEC;
                    misalign = 1'b1;
                end
`endif
            end
            SEL_J:  next_pc = {pc_plus4[31:28], jump_target};
            SEL_BR: next_pc = pc_plus4 + branch_offset;
            default: begin
                next_pc     = pc_plus4;
                is_redirect = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/next_pc_unit.sv
// PC register, fetch handshake and stall-tolerant redirect holding.
// Ports: clk_i, rst_i (async low), stall_i, req_ready_i, jump/branch/jr
// controls -> pc_o, pc_plus4_o, req_valid_o, redirect_o.
// Option NEXT_PC_MISALIGN_TRAP_EN: misaligned jr traps, adds misalign_o.
module next_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
`ifdef NEXT_PC_MISALIGN_TRAP_EN
   ,parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
`endif
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    input  logic        jump_i,
    input  logic [27:0] jump_target_i,
    input  logic        branch_i,
    input  logic [31:0] branch_offset_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
`ifdef NEXT_PC_MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
   ,output logic        redirect_o
);

    pc_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        redir_q, redir_d;
    logic [31:0] next_pc;
    logic        is_redirect;
    logic        advance;
    logic [31:0] hold_tgt;

`ifdef NEXT_PC_MISALIGN_TRAP_EN
    logic sel_mis;
    logic mis_q, mis_d;
    logic pmis_q, pmis_d;
`endif

    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_q + 32'd4;
    assign redirect_o  = redir_q;
    assign req_valid_o = (state_q != BOOT);
    assign advance     = req_ready_i & ~stall_i;
    // A redirect arriving in HOLD replaces the held one
    assign hold_tgt    = is_redirect ? next_pc : pend_q;

    next_pc_select
`ifdef NEXT_PC_MISALIGN_TRAP_EN
    #(.TRAP_VEC(TRAP_VEC))
`endif
    u_sel (
        .pc_plus4      (pc_plus4_o),
        .jump          (jump_i),
        .jump_target   (jump_target_i),
        .branch        (branch_i),
        .branch_offset (branch_offset_i),
        .jr            (jr_i),
        .jr_target     (jr_target_i),
`ifdef NEXT_PC_MISALIGN_TRAP_EN
        .misalign      (sel_mis),
`endif
        .next_pc       (next_pc),
        .is_redirect   (is_redirect)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        redir_d = 1'b0;
`ifdef NEXT_PC_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
        pmis_d  = pmis_q;
`endif
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (advance) begin
                    pc_d    = next_pc;
                    redir_d = is_redirect;
`ifdef NEXT_PC_MISALIGN_TRAP_EN
                    mis_d   = sel_mis;
`endif
                end else if (is_redirect) begin
                    pend_d  = next_pc;
                    state_d = HOLD;
`ifdef NEXT_PC_MISALIGN_TRAP_EN
                    pmis_d  = sel_mis;
`endif
                end
            end
            HOLD: begin
                pend_d = hold_tgt;
`ifdef NEXT_PC_MISALIGN_TRAP_EN
                if (is_redirect)
                    pmis_d = sel_mis;
`endif
                if (advance) begin
                    pc_d    = hold_tgt;
                    redir_d = 1'b1;
                    state_d = RUN;
`ifdef NEXT_PC_MISALIGN_TRAP_EN
                    mis_d   = is_redirect ? sel_mis : pmis_q;
`endif
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= RESET_PC;
            redir_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            redir_q <= redir_d;
        end
    end

`ifdef NEXT_PC_MISALIGN_TRAP_EN
    assign misalign_o = mis_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mis_q  <= 1'b0;
            pmis_q <= 1'b0;
        end else begin
            mis_q  <= mis_d;
            pmis_q <= pmis_d;
        end
    end
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed cases then random
// stimulus compared against a behavioural PC model.
module tb_next_pc_unit;

    localparam logic [31:0] TRAP = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic        jump_i;
    logic [27:0] jump_target_i;
    logic        branch_i;
    logic [31:0] branch_offset_i;
    logic        jr_i;
    logic [31:0] jr_target_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        redirect_o;
`ifdef NEXT_PC_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    bit          m_booted;
    bit          m_hold;
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_pend_mis;
    bit          m_redir;
    bit          m_mis;

    always #5 clk = ~clk;

    next_pc_unit dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .req_valid_o     (req_valid_o),
        .req_ready_i     (req_ready_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .branch_i        (branch_i),
        .branch_offset_i (branch_offset_i),
        .jr_i            (jr_i),
        .jr_target_i     (jr_target_i),
`ifdef NEXT_PC_MISALIGN_TRAP_EN
        .misalign_o      (misalign_o),
`endif
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .redirect_o      (redirect_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc_o, m_pc);
        check({tag, ".pc4"}, pc_plus4_o, m_pc + 32'd4);
        check({tag, ".valid"}, {31'd0, req_valid_o}, {31'd0, m_booted});
        check({tag, ".redir"}, {31'd0, redirect_o}, {31'd0, m_redir});
`ifdef NEXT_PC_MISALIGN_TRAP_EN
        check({tag, ".mis"}, {31'd0, misalign_o}, {31'd0, m_mis});
`endif
    endtask

    task automatic model_reset();
        m_booted   = 0;
        m_hold     = 0;
        m_pc       = 32'h0;
        m_pend     = 32'h0;
        m_pend_mis = 0;
        m_redir    = 0;
        m_mis      = 0;
    endtask

    // One clock of the model using the currently driven inputs
    task automatic model_step();
        logic [31:0] p4;
        logic [31:0] tgt;
        bit red;
        bit mis;
        bit adv;
        p4  = m_pc + 32'd4;
        red = jr_i || jump_i || branch_i;
        mis = 0;
        if (jr_i) begin
            tgt = jr_target_i;
`ifdef NEXT_PC_MISALIGN_TRAP_EN
            if (jr_target_i % 4 != 0) begin
                tgt = TRAP;
                mis = 1;
            end
`endif
        end else if (jump_i)
            tgt = {p4[31:28], jump_target_i};
        else if (branch_i)
            tgt = p4 + branch_offset_i;
        else
            tgt = p4;
        adv     = req_ready_i && !stall_i;
        m_redir = 0;
        m_mis   = 0;
        if (!m_booted) begin
            m_booted = 1;
        end else if (m_hold) begin
            if (red) begin
                m_pend     = tgt;
                m_pend_mis = mis;
            end
            if (adv) begin
                m_pc    = m_pend;
                m_redir = 1;
                m_mis   = m_pend_mis;
                m_hold  = 0;
            end
        end else if (adv) begin
            m_pc    = tgt;
            m_redir = red;
            m_mis   = mis;
        end else if (red) begin
            m_hold     = 1;
            m_pend     = tgt;
            m_pend_mis = mis;
        end
    endtask

    task automatic drive(input bit st, input bit rdy, input bit j,
                         input logic [27:0] jt, input bit br,
                         input logic [31:0] off, input bit r,
                         input logic [31:0] rt);
        stall_i         = st;
        req_ready_i     = rdy;
        jump_i          = j;
        jump_target_i   = jt;
        branch_i        = br;
        branch_offset_i = off;
        jr_i            = r;
        jr_target_i     = rt;
    endtask

    task automatic cyc(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        drive(0, 1, 0, 28'h0, 0, 32'h0, 0, 32'h0);
        cyc(tag);
    endtask

    task automatic do_jr(input string tag, input logic [31:0] t);
        drive(0, 1, 0, 28'h0, 0, 32'h0, 1, t);
        cyc(tag);
    endtask

    initial begin
        drive(0, 1, 0, 28'h0, 0, 32'h0, 0, 32'h0);
        rst_i = 1'b0;
        model_reset();
        #1;
        check_all("rst");
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        check_all("boot");
        check("boot.pc0", pc_o, 32'h0);

        idle("run");
        check("run.valid", {31'd0, req_valid_o}, 32'd1);
        idle("seq1");
        check("seq.4", pc_o, 32'h4);
        idle("seq2");
        check("seq.8", pc_o, 32'h8);
        idle("seq3");
        check("seq.c", pc_o, 32'hC);

        do_jr("jr0", 32'h1000_0010);
        drive(0, 1, 1, 28'h000_0040, 0, 32'h0, 0, 32'h0);
        cyc("jmp");
        check("jmp.pc", pc_o, 32'h1000_0040);
        check("jmp.redir", {31'd0, redirect_o}, 32'd1);
        idle("jmp.after");
        check("jmp.pulse", {31'd0, redirect_o}, 32'd0);

        drive(0, 1, 1, 28'h0AB_CDE0, 1, 32'h40, 1, 32'h0000_2000);
        cyc("prio");
        check("prio.pc", pc_o, 32'h0000_2000);

        do_jr("jr100", 32'h0000_0100);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 28'h0, (i == 0), 32'hFFFF_FFF0, 0, 32'h0);
            cyc("stall");
            check("stall.pc", pc_o, 32'h100);
        end
        idle("release");
        check("release.pc", pc_o, 32'hF4);
        check("release.redir", {31'd0, redirect_o}, 32'd1);
        idle("release.after");
        check("release.pulse", {31'd0, redirect_o}, 32'd0);

        do_jr("jrtop", 32'hFFFF_FFFC);
        idle("wrap");
        check("wrap.pc", pc_o, 32'h0);

        // memory not ready: PC must stay put with valid high
        drive(0, 0, 1, 28'h000_0200, 0, 32'h0, 0, 32'h0);
        cyc("nrdy");
        drive(0, 0, 0, 28'h0, 1, 32'h8, 0, 32'h0);
        cyc("nrdy2");
        idle("nrdy.go");

`ifdef NEXT_PC_MISALIGN_TRAP_EN
        do_jr("mis", 32'h0000_2002);
        check("mis.pc", pc_o, TRAP);
        check("mis.flag", {31'd0, misalign_o}, 32'd1);
        idle("mis.after");
        check("mis.pulse", {31'd0, misalign_o}, 32'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            logic [31:0] rt;
            rt = $urandom;
            if ($urandom_range(0, 3) != 0)
                rt[1:0] = 2'b00;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 5) == 0, 28'($urandom),
                  $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 1) == 1) ? $urandom
                      : 32'($signed($urandom_range(0, 255)) - 128) << 2,
                  $urandom_range(0, 7) == 0, rt);
            cyc("rnd");
        end

        // asynchronous reset while a redirect is being held
        drive(1, 1, 0, 28'h0, 1, 32'h400, 0, 32'h0);
        cyc("pre.rst");
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        idle("arst.boot");
        idle("arst.run");
        check("arst.pc", pc_o, 32'h4);
        check("arst.redir", {31'd0, redirect_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Program-counter register and next-PC selector for the single-cycle CPU.
- Consumes the 28-bit word-aligned jump field produced by the shift-left-two stage and concatenates it with PC+4[31:28] to form the jump address.
- Also handles taken branches and register jumps (jr), and drives the fetch address to instruction memory through a valid/ready handshake.
- Holds a redirect that arrives during a stall so that it is applied on the next advance.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0080, PC target used on a misaligned jr (only when the optional feature is compiled in).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- stall_i  in  1  pipeline/hazard hold; PC must not advance while high.
- req_valid_o  out  1  fetch request valid.
- req_ready_i  in  1  instruction memory accepts the request.
- jump_i  in  1  j/jal decoded this cycle.
- jump_target_i  in  28  shifted jump field ({instr[25:0],2'b00}).
- branch_i  in  1  branch taken this cycle.
- branch_offset_i  in  32  sign-extended byte offset, already shifted by 2.
- jr_i  in  1  jr decoded this cycle.
- jr_target_i  in  32  register operand for jr.
- pc_o  out  32  current fetch PC.
- pc_plus4_o  out  32  pc_o + 4, combinational, for link/branch use.
- redirect_o  out  1  one-cycle pulse when a non-sequential PC is loaded.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - pc_o=RESET_PC, req_valid_o=0, redirect_o=0, pending register cleared, state=BOOT.
  - Reset asserted mid-operation discards any pending redirect immediately.
- FSM states: BOOT, RUN, HOLD.
  - BOOT: one cycle after reset release, move to RUN with req_valid_o=1. Redirect inputs are ignored in BOOT.
  - RUN: advance = req_ready_i & ~stall_i.
    - On advance: pc_o <= next_pc.
    - A redirect present without advance: capture its target into pend_pc, set state=HOLD, pc_o unchanged.
  - HOLD: pc_o unchanged; req_valid_o stays 1.
    - A new redirect in HOLD overwrites pend_pc (newest wins).
    - On advance: pc_o <= pend_pc, pulse redirect_o, return to RUN.
- next_pc priority (same cycle): jr > jump > branch > sequential.
  - jr: jr_target_i.
  - jump: {pc_plus4[31:28], jump_target_i}.
  - branch: pc_plus4 + branch_offset_i, modulo 2^32 (wraps silently).
  - sequential: pc_plus4; 32'hFFFF_FFFC + 4 wraps to 0.
- redirect_o is registered.
  - High for exactly the cycle after pc_o loads a non-sequential target (from RUN or HOLD).
  - Low otherwise, including after sequential advances.
- req_valid_o is held high in RUN and HOLD. pc_o must be stable while req_valid_o=1 and req_ready_i=0.
- Latency: one clock from an advance edge to the new pc_o.
- jr_target_i[1:0]≠0 without the optional feature: target used as-is, no check.

Optional Feature:
- Macro: NEXT_PC_MISALIGN_TRAP_EN.
- When defined:
  - A jr whose target has [1:0]≠0 loads TRAP_VEC instead of the target.
  - Adds output misalign_o (1 bit, reset 0), pulsed for one cycle together with redirect_o.
  - The check also applies to a target captured in HOLD.
- When undefined: no misalign_o port, no check, no TRAP_VEC use.

Decomposition:
- Shared package (cpu_pkg):
  - constants RESET_PC_DEF and TRAP_VEC_DEF.
  - enum pc_state_t {BOOT, RUN, HOLD}.
  - enum pc_sel_t {SEL_SEQ, SEL_BR, SEL_J, SEL_JR}.
- One sub-module, next_pc_select: purely combinational priority mux plus the adder, producing next_pc and an is_redirect flag. The top level keeps the FSM, the PC register and the pend_pc register.

Test Plan:
- Reset release, req_ready_i=1, no controls:
  - pc_o=0 in BOOT; then req_valid_o=1.
  - pc_o steps 0,4,8,C on successive cycles; redirect_o stays 0.
- pc_o=0x1000_0010, jump_i=1, jump_target_i=28'h0000_040 → next pc_o=0x1000_0040; redirect_o=1 for one cycle.
- Same cycle: jr_i=1 (target 0x0000_2000), jump_i=1, branch_i=1 → pc_o=0x0000_2000 (jr wins).
- pc_o=0x100, branch_i=1, branch_offset_i=0xFFFF_FFF0, stall_i=1 for 3 cycles:
  - pc_o holds 0x100; state=HOLD.
  - Stall release: pc_o=0xF4; redirect_o pulses once.
- Sequential step at pc_o=0xFFFF_FFFC → pc_o=0x0000_0000.
  - With NEXT_PC_MISALIGN_TRAP_EN defined: jr to 0x0000_2002 → pc_o=TRAP_VEC (0x80); misalign_o=1 for one cycle.
